// File: rtl/fsqrt_unit.sv
// fsqrt_unit: handshaked two-stage wrapper around a combinational
// single-precision square root core.
//
// Ports:
//   clk, rstn                  clock (rising edge), async active-low reset
//   in_valid/in_ready          upstream handshake
//   in_x[31:0], in_tag[TAG_W]  operand and opaque destination tag
//   flush                      synchronous kill of everything in flight
//   out_valid/out_ready        downstream handshake
//   out_y[31:0], out_tag       result and its tag
//   out_invalid                IEEE invalid-operation flag for out_y
//
// Stage 1 holds the operand, tag and its IEEE class. Stage 2 is the output
// register, loaded with either the core result or a special-case override.

// Combinational square root for positive normal operands. The mantissa root
// is formed by a restoring digit-by-digit integer square root and truncated
// (at most 1 ulp low). Zero, negative, inf and NaN operands are handled by
// the wrapper, so their results here are don't-care.
module fsqrt (
    input  logic [31:0] x,
    output logic [31:0] y
);

    logic [47:0] rad;
    logic [25:0] rem;
    logic [25:0] trial;
    logic [23:0] root;
    logic [7:0]  exp_r;

    always_comb begin
        // Odd biased exponent means even unbiased exponent: radicand is
        // M << 23; otherwise one extra shift absorbs the odd power of two.
        if (x[23]) begin
            rad = {1'b0, 1'b1, x[22:0], 23'b0};
        end else begin
            rad = {1'b1, x[22:0], 24'b0};
        end

        rem   = '0;
        root  = '0;
        trial = '0;
        for (int i = 23; i >= 0; i--) begin
            rem   = {rem[23:0], rad[2*i+1 -: 2]};
            trial = {root, 2'b01};
            if (rem >= trial) begin
                rem  = rem - trial;
                root = {root[22:0], 1'b1};
            end else begin
                root = {root[22:0], 1'b0};
            end
        end

        // floor((E - 127) / 2) + 127 == (E + 127) >> 1 for both parities
        exp_r = 8'(({1'b0, x[30:23]} + 9'd127) >> 1);

        // root[23] is the hidden bit and is always set for a normal operand
        y = root[23] ? {x[31], exp_r, root[22:0]} : 32'd0;
    end

endmodule

module fsqrt_unit #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_invalid
);

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_NEG,
        CLS_INF,
        CLS_NAN,
        CLS_NORM
    } cls_e;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_x_q, s1_x_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    cls_e             s1_cls_q, s1_cls_d;

    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      out_y_q, out_y_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_inv_q, out_inv_d;

    logic             s1_en, s2_en;
    cls_e             in_cls;
    logic [31:0]      sqrt_y;
    logic [31:0]      res_y;
    logic             res_inv;

    // Ready depends only on pipeline occupancy, out_ready and flush; never
    // on in_valid.
    assign s2_en    = !s2_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en && !flush;

    // Denormals count as zero (sign kept); -0 and negative denormals are
    // therefore not "negative". NaN takes priority over the sign.
    always_comb begin
        if (in_x[30:23] == 8'd0) begin
            in_cls = CLS_ZERO;
        end else if (in_x[30:23] == 8'hFF && in_x[22:0] != 23'd0) begin
            in_cls = CLS_NAN;
        end else if (in_x[31]) begin
            in_cls = CLS_NEG;
        end else if (in_x[30:23] == 8'hFF) begin
            in_cls = CLS_INF;
        end else begin
            in_cls = CLS_NORM;
        end
    end

    fsqrt u_fsqrt (
        .x (s1_x_q),
        .y (sqrt_y)
    );

    always_comb begin
        res_y   = sqrt_y;
        res_inv = 1'b0;
        case (s1_cls_q)
            CLS_ZERO: res_y = {s1_x_q[31], 31'b0};
            CLS_NEG: begin
                res_y   = QNAN;
                res_inv = 1'b1;
            end
            CLS_INF:  res_y = POS_INF;
            CLS_NAN: begin
                res_y   = QNAN;
                res_inv = !s1_x_q[22];  // signalling NaN only
            end
            default:  res_y = sqrt_y;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_tag_d   = s1_tag_q;
        s1_cls_d   = s1_cls_q;
        s2_valid_d = s2_valid_q;
        out_y_d    = out_y_q;
        out_tag_d  = out_tag_q;
        out_inv_d  = out_inv_q;

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid_d = in_valid;
                if (in_valid) begin
                    s1_x_d   = in_x;
                    s1_tag_d = in_tag;
                    s1_cls_d = in_cls;
                end
            end
            if (s2_en) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    out_y_d   = res_y;
                    out_tag_d = s1_tag_q;
                    out_inv_d = res_inv;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_tag_q   <= '0;
            s1_cls_q   <= CLS_ZERO;
            s2_valid_q <= 1'b0;
            out_y_q    <= '0;
            out_tag_q  <= '0;
            out_inv_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_tag_q   <= s1_tag_d;
            s1_cls_q   <= s1_cls_d;
            s2_valid_q <= s2_valid_d;
            out_y_q    <= out_y_d;
            out_tag_q  <= out_tag_d;
            out_inv_q  <= out_inv_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_y       = out_y_q;
    assign out_tag     = out_tag_q;
    assign out_invalid = out_inv_q;

endmodule

// File: tb/tb_fsqrt_unit.sv
module tb_fsqrt_unit;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [5:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic [5:0]  out_tag;
    logic        out_invalid;

    fsqrt_unit #(.TAG_W(6)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_tag      (in_tag),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_y       (out_y),
        .out_tag     (out_tag),
        .out_invalid (out_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] y;
        logic [5:0]  tag;
        logic        inv;
        int          tol;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input bit ok,
                         input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    function automatic logic [31:0] ref_sqrt(input logic [31:0] x);
        logic [63:0] d;
        real         r;
        d = {1'b0, 11'(x[30:23]) + 11'd896, x[22:0], 29'b0};
        r = $sqrt($bitstoreal(d));
        d = $realtobits(r);
        return {1'b0, 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    task automatic push(input logic [31:0] ey, input logic [5:0] tag,
                        input logic einv, input int tol);
        exp_t e;
        e.y = ey; e.tag = tag; e.inv = einv; e.tol = tol;
        sb.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] x, input logic [5:0] tag,
                        input logic [31:0] ey, input logic einv, input int tol,
                        input bit do_push, output int waits);
        bit acc;
        acc   = 1'b0;
        waits = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_tag   = tag;
        while (!acc && waits < 50) begin
            @(negedge clk);
            acc = in_ready;
            if (acc && do_push) push(ey, tag, einv, tol);
            @(posedge clk); #1;
            if (!acc) waits++;
        end
        if (!acc) check("send_timeout", 1'b0, 64'(waits), 64'd0);
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", sb.size() == 0, 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: compares every output transfer against the queue.
    initial begin
        exp_t    e;
        longint  diff;
        forever begin
            @(negedge clk);
            if (rstn && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1'b0, 64'(out_y), 64'(out_tag));
                end else begin
                    e = sb.pop_front();
                    diff = longint'(out_y) - longint'(e.y);
                    if (diff < 0) diff = -diff;
                    check("out_y", (out_y[31] == e.y[31]) && (diff <= longint'(e.tol)),
                          64'(out_y), 64'(e.y));
                    check("out_tag", out_tag == e.tag, 64'(out_tag), 64'(e.tag));
                    check("out_invalid", out_invalid == e.inv,
                          64'(out_invalid), 64'(e.inv));
                end
            end
        end
    end

    initial begin
        int w;
        int stalls;
        logic [31:0] xr;

        rstn = 1'b0; in_valid = 1'b0; in_x = '0; in_tag = '0;
        flush = 1'b0; out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", out_valid == 1'b0, 64'(out_valid), 64'd0);
        check("rst_out_y", out_y == 32'd0, 64'(out_y), 64'd0);
        check("rst_out_tag", out_tag == 6'd0, 64'(out_tag), 64'd0);
        check("rst_out_invalid", out_invalid == 1'b0, 64'(out_invalid), 64'd0);
        @(negedge clk); rstn = 1'b1; #1;
        check("rst_in_ready", in_ready == 1'b1, 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Basic latency: sqrt(4.0) = 2.0, out_valid on the second edge
        out_ready = 1'b1;
        send(32'h4080_0000, 6'd5, 32'h4000_0000, 1'b0, 7, 1'b1, w);
        idle_in();
        check("lat_edge1_out_valid", out_valid == 1'b0, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_edge2_out_valid", out_valid == 1'b1, 64'(out_valid), 64'd1);
        drain();

        // Special cases, back-to-back
        send(32'h8000_0000, 6'd1, 32'h8000_0000, 1'b0, 0, 1'b1, w);
        send(32'hBF80_0000, 6'd2, 32'h7FC0_0000, 1'b1, 0, 1'b1, w);
        send(32'h7F80_0000, 6'd3, 32'h7F80_0000, 1'b0, 0, 1'b1, w);
        send(32'h7FA0_0000, 6'd4, 32'h7FC0_0000, 1'b1, 0, 1'b1, w);
        send(32'h0000_0001, 6'd5, 32'h0000_0000, 1'b0, 0, 1'b1, w);
        send(32'h7FC0_0000, 6'd6, 32'h7FC0_0000, 1'b0, 0, 1'b1, w);
        send(32'h3E80_0000, 6'd7, 32'h3F00_0000, 1'b0, 0, 1'b1, w);
        idle_in();
        drain();

        // Streaming accuracy at full rate
        stalls = 0;
        for (int i = 0; i < 1000; i++) begin
            xr = {1'b0, 8'($urandom_range(254, 1)), 23'($urandom)};
            send(xr, 6'(i), ref_sqrt(xr), 1'b0, 7, 1'b1, w);
            stalls += w;
        end
        idle_in();
        check("stream_stalls", stalls == 0, 64'(stalls), 64'd0);
        @(posedge clk);
        @(negedge clk); #1;
        check("stream_no_gaps", sb.size() == 0, 64'(sb.size()), 64'd0);
        drain();

        // Backpressure
        out_ready = 1'b0;
        send(32'h3F80_0000, 6'd10, 32'h3F80_0000, 1'b0, 7, 1'b1, w);
        send(32'h4110_0000, 6'd11, 32'h4040_0000, 1'b0, 7, 1'b1, w);
        in_valid = 1'b1; in_x = 32'h4180_0000; in_tag = 6'd12;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", in_ready == 1'b0, 64'(in_ready), 64'd0);
            check("bp_out_y_hold", out_valid && out_y == 32'h3F80_0000,
                  64'(out_y), 64'h3F80_0000);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_accept_on_release", in_ready == 1'b1, 64'(in_ready), 64'd1);
        push(32'h4080_0000, 6'd12, 1'b0, 7);
        @(posedge clk); #1;
        idle_in();
        drain();

        // Flush with two in flight
        out_ready = 1'b0;
        send(32'h3F80_0000, 6'd20, 32'h3F80_0000, 1'b0, 7, 1'b0, w);
        send(32'h4110_0000, 6'd21, 32'h4040_0000, 1'b0, 7, 1'b0, w);
        flush = 1'b1; in_valid = 1'b1; in_x = 32'h4180_0000; in_tag = 6'd23;
        @(negedge clk);
        check("flush_in_ready", in_ready == 1'b0, 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; idle_in();
        check("flush_out_valid", out_valid == 1'b0, 64'(out_valid), 64'd0);
        check("flush_out_y_kept", out_y == 32'h3F80_0000, 64'(out_y), 64'h3F80_0000);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("flush_no_result", out_valid == 1'b0, 64'(out_valid), 64'd0);
        end
        send(32'h4080_0000, 6'd22, 32'h4000_0000, 1'b0, 7, 1'b1, w);
        idle_in();
        check("post_flush_edge1", out_valid == 1'b0, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("post_flush_edge2", out_valid == 1'b1, 64'(out_valid), 64'd1);
        drain();

        // Asynchronous reset with two in flight
        out_ready = 1'b0;
        send(32'h4080_0000, 6'd30, 32'h4000_0000, 1'b0, 7, 1'b0, w);
        send(32'h4110_0000, 6'd31, 32'h4040_0000, 1'b0, 7, 1'b0, w);
        idle_in();
        #2; rstn = 1'b0; #1;
        check("arst_out_valid", out_valid == 1'b0, 64'(out_valid), 64'd0);
        check("arst_out_y", out_y == 32'd0, 64'(out_y), 64'd0);
        check("arst_out_tag", out_tag == 6'd0, 64'(out_tag), 64'd0);
        @(negedge clk); #1; rstn = 1'b1; #1;
        check("arst_in_ready", in_ready == 1'b1, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("arst_no_result", out_valid == 1'b0, 64'(out_valid), 64'd0);
        end
        send(32'h4180_0000, 6'd33, 32'h4080_0000, 1'b0, 7, 1'b1, w);
        idle_in();
        drain();

        check("sb_empty", sb.size() == 0, 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fsqrt_unit.md
Name: fsqrt_unit

Overview:
- Handshaked, 2-stage pipelined wrapper around the combinational single-precision `fsqrt` core.
- Sits between the FPU issue logic and the FPU result writeback.
- Upstream side: accepts an operand plus destination tag and registers it, classifying IEEE-754 special cases.
- Downstream side: drives the registered `fsqrt` result, or the special-case override, to writeback with a valid/ready handshake and full backpressure.

Parameters:
- TAG_W, 6, width of the opaque destination tag carried alongside each operation.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream holds an operation.
- in_ready  out  1  unit can accept an operation this cycle.
- in_x  in  32  IEEE-754 single operand.
- in_tag  in  TAG_W  destination tag.
- flush  in  1  synchronous kill of all in-flight operations.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_y  out  32  IEEE-754 single result.
- out_tag  out  TAG_W  tag of the result.
- out_invalid  out  1  IEEE invalid-operation flag for this result.

Behaviour:
- Reset (rstn low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, out_y=0, out_tag=0, out_invalid=0. in_ready=1 immediately after release.
- Transfers: an input transfer occurs when in_valid & in_ready at a clock edge; an output transfer when out_valid & out_ready.
- Stage 1 (S1) register: operand, tag, class. Class is computed from in_x before registering:
  - ZERO: exp=0; mantissa ignored; denormals flush to zero, sign kept.
  - NEG: sign=1, nonzero, not NaN.
  - INF: +inf.
  - NAN: exp=255, mantissa≠0.
  - NORM: everything else.
- The combinational `fsqrt` is instantiated once, fed from the S1 operand register.
- Stage 2 (S2) register = out_* registers. out_y is selected per class:
  - ZERO → {sign,31'b0}.
  - NEG → 0x7FC00000 with out_invalid=1.
  - INF → 0x7F800000.
  - NAN → 0x7FC00000; out_invalid=1 only if the input was a signalling NaN (mantissa bit22=0).
  - NORM → fsqrt output unchanged (±7 ulp accuracy, owned by `fsqrt`).
  - out_invalid=0 for every case not listed above.
- Advance rules (per cycle):
  - s2_en = !s2_valid | out_ready.
  - s1_en = !s1_valid | s2_en.
  - in_ready = s1_en (combinational from out_ready; no combinational path from in_valid to in_ready).
  - S2 loads from S1 when s2_en; s2_valid_next = s1_valid.
  - S1 loads from the input when s1_en; s1_valid_next = in_valid.
- Latency: exactly 2 cycles from accepted input to out_valid with out_ready held high. Throughput 1/cycle. Maximum occupancy 2 operations.
- Ordering: results leave in acceptance order; tags are never reordered.
- Stall: while out_valid=1 and out_ready=0, out_y/out_tag/out_invalid are stable. S1 keeps its contents if occupied; if S1 is empty, one more input is accepted into S1, after which in_ready=0.
- Simultaneous accept and release:
  - Full pipe with out_ready=1 and in_valid=1: both transfers happen in the same cycle; no bubble.
- Flush (synchronous):
  - Next edge clears s1_valid and s2_valid.
  - in_ready is forced to 0 during the flush cycle, and any input presented that cycle is dropped.
  - out_y/out_tag retain their value but out_valid=0.
- Reset mid-operation discards all in-flight operations; no partial result is ever emitted.
- Datapath registers, excluding the valid bits, may be left unreset except out_*, which reset to 0.

Test Plan:
- Basic latency: reset, out_ready=1, in_x=0x40800000 (4.0) tag=5 at cycle 0 → out_valid=1 at cycle 2, out_y within 0x40000000±7, out_tag=5, out_invalid=0.
- Special cases, back-to-back one per cycle:
  - Inputs 0x80000000, 0xBF800000, 0x7F800000, 0x7FA00000, 0x00000001.
  - Required outputs in order: 0x80000000/0, 0x7FC00000/1, 0x7F800000/0, 0x7FC00000/1, 0x00000000/0.
- Streaming accuracy: 1000 random positive normals at full rate, tags incrementing → every result within ±7 ulp of $sqrt, tags strictly in order, no gaps.
- Backpressure:
  - Hold out_ready=0 while offering 3 ops (1.0, 9.0, 16.0) → in_ready drops after 2 accepted; out_y holds ≈0x3F800000 steady.
  - Release out_ready → 0x3F800000, 0x40400000, 0x40800000 delivered in order, third accepted the cycle out_ready rises.
- Flush: two ops in flight, assert flush for 1 cycle → out_valid=0 next cycle, neither result ever appears; the next accepted op emerges 2 cycles later.
- Async reset: drop rstn between edges with 2 ops in flight → out_valid, out_y and out_tag go to 0 immediately without a clock; in_ready=1 after release.
